// File: rtl/dot_row_accumulator.sv
// dot_row_accumulator
//   Sums NUM_CHUNKS successive signed 16-bit partial dot products together with a
//   per-row bias, then narrows the row total back to 16 bits. The result is held
//   under a valid/ready handshake until the activation stage takes it.
//
//   Optional feature macro: DOT_ACC_SAT_EN
//     defined   : the 16-bit result saturates to 16'h7FFF / 16'h8000 and ovf flags the clamp
//     undefined : the 16-bit result is plain truncation (wraps) and ovf is tied to 0
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   clear      in   synchronous abort of the current row (priority over in_valid)
//   in_valid   in   partial sum present on in_data
//   in_ready   out  partial sum can be accepted (== ~out_valid)
//   in_data    in   signed 16-bit partial dot product
//   bias       in   signed 16-bit row bias, sampled on the first chunk of a row
//   out_valid  out  row result available
//   out_ready  in   consumer accepts the result
//   out_data   out  signed 16-bit row result
//   ovf        out  result was clamped (qualified by out_valid)
//   busy       out  row in progress or result pending

module dot_row_accumulator #(
    parameter int unsigned NUM_CHUNKS = 8,
    parameter int unsigned ACC_W      = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic [15:0] bias,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        ovf,
    output logic        busy
);

    localparam int unsigned CNT_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;

    logic             accept;
    logic             last_chunk;
    logic [ACC_W-1:0] acc_base;
    logic [ACC_W-1:0] acc_next;
    logic [15:0]      narrow_data;
    logic             narrow_ovf;

    assign in_ready   = ~out_valid;
    assign busy       = (cnt != '0) | out_valid;
    assign accept     = in_valid & in_ready & ~clear;
    assign last_chunk = (cnt == LAST_CNT);

    // First chunk of a row starts from the bias instead of the running sum.
    assign acc_base = (cnt == '0) ? {{(ACC_W-16){bias[15]}}, bias} : acc;
    assign acc_next = acc_base + {{(ACC_W-16){in_data[15]}}, in_data};

`ifdef DOT_ACC_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

    always_comb begin
        narrow_data = acc_next[15:0];
        narrow_ovf  = 1'b0;
        if ($signed(acc_next) > SAT_MAX) begin
            narrow_data = 16'h7FFF;
            narrow_ovf  = 1'b1;
        end else if ($signed(acc_next) < SAT_MIN) begin
            narrow_data = 16'h8000;
            narrow_ovf  = 1'b1;
        end
    end
`else
    // Upper accumulator bits are only needed by the saturation comparators.
    logic unused_acc_hi;
    assign unused_acc_hi = ^acc_next[ACC_W-1:16];

    assign narrow_data = acc_next[15:0];
    assign narrow_ovf  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= 16'h0000;
            ovf       <= 1'b0;
        end else if (clear) begin
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            // accept implies !out_valid, so it never collides with the drain above.
            if (accept) begin
                if (last_chunk) begin
                    out_data  <= narrow_data;
                    ovf       <= narrow_ovf;
                    out_valid <= 1'b1;
                    cnt       <= '0;
                    acc       <= '0;
                end else begin
                    acc <= acc_next;
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_dot_row_accumulator.sv
// tb_dot_row_accumulator
//   Directed self-checking bench for dot_row_accumulator (NUM_CHUNKS=8, ACC_W=24).
//   Expected values are hand-computed constants; the saturating variants are
//   selected when DOT_ACC_SAT_EN is defined.

module tb_dot_row_accumulator;

    logic        clk;
    logic        rst;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [15:0] bias;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        ovf;
    logic        busy;

    int total;
    int bad;

    dot_row_accumulator #(
        .NUM_CHUNKS(8),
        .ACC_W     (24)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .bias     (bias),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .ovf      (ovf),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present n chunks back to back; returns #1 after the edge of the last accept.
    task automatic send_row(input logic [15:0] b, input logic [15:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = d;
            bias     = b;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_data  = 16'h0000;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL drain_out_valid: got %b want 0", out_valid);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        bias      = 16'h0000;
        out_ready = 1'b0;
        #12;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++;
        if (out_data !== 16'h0000) begin bad++; $display("FAIL reset_out_data: got %h want 0000", out_data); end
        total++;
        if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic_row();
        out_ready = 1'b1;
        send_row(16'h0100, 16'h0010, 7);
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_mid_row: got valid=%b busy=%b want valid=0 busy=1", out_valid, busy);
        end
        send_row(16'h0100, 16'h0010, 1);
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_out_valid: got %b want 1", out_valid); end
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL basic_in_ready: got %b want 0", in_ready); end
        total++;
        if (out_data !== 16'h0180) begin bad++; $display("FAIL basic_out_data: got %h want 0180", out_data); end
        total++;
        if (ovf !== 1'b0) begin bad++; $display("FAIL basic_ovf: got %b want 0", ovf); end
        drain();
    endtask

    task automatic test_pos_overflow();
        logic [15:0] exp_data;
        logic        exp_ovf;
`ifdef DOT_ACC_SAT_EN
        exp_data = 16'h7FFF;
        exp_ovf  = 1'b1;
`else
        exp_data = 16'h8000;
        exp_ovf  = 1'b0;
`endif
        send_row(16'h0000, 16'h7000, 8);
        total++;
        if (out_valid !== 1'b1 || out_data !== exp_data) begin
            bad++;
            $display("FAIL pos_ovf_data: got valid=%b data=%h want valid=1 data=%h", out_valid, out_data, exp_data);
        end
        total++;
        if (ovf !== exp_ovf) begin bad++; $display("FAIL pos_ovf_flag: got %b want %b", ovf, exp_ovf); end
        drain();
    endtask

    task automatic test_neg_overflow();
        logic [15:0] exp_data;
        logic        exp_ovf;
`ifdef DOT_ACC_SAT_EN
        exp_data = 16'h8000;
        exp_ovf  = 1'b1;
`else
        exp_data = 16'hFF00;
        exp_ovf  = 1'b0;
`endif
        send_row(16'hFF00, 16'hC000, 8);
        total++;
        if (out_valid !== 1'b1 || out_data !== exp_data) begin
            bad++;
            $display("FAIL neg_ovf_data: got valid=%b data=%h want valid=1 data=%h", out_valid, out_data, exp_data);
        end
        total++;
        if (ovf !== exp_ovf) begin bad++; $display("FAIL neg_ovf_flag: got %b want %b", ovf, exp_ovf); end
        drain();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send_row(16'h0000, 16'h0001, 8);
        total++;
        if (out_data !== 16'h0008) begin bad++; $display("FAIL bp_first_row: got %h want 0008", out_data); end
        in_valid = 1'b1;
        in_data  = 16'h0001;
        bias     = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || busy !== 1'b1 || out_data !== 16'h0008) begin
                bad++;
                $display("FAIL bp_hold[%0d]: got rdy=%b vld=%b busy=%b data=%h want rdy=0 vld=1 busy=1 data=0008",
                         i, in_ready, out_valid, busy, out_data);
            end
        end
        in_valid = 1'b0;
        drain();
        // Next row must start from its own bias: 0x20 + 8*3 = 0x38.
        send_row(16'h0020, 16'h0003, 8);
        total++;
        if (out_valid !== 1'b1 || out_data !== 16'h0038) begin
            bad++;
            $display("FAIL bp_next_row: got valid=%b data=%h want valid=1 data=0038", out_valid, out_data);
        end
        drain();
    endtask

    task automatic test_clear();
        send_row(16'h0000, 16'h1000, 3);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h1000;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL clear_idle: got busy=%b valid=%b want busy=0 valid=0", busy, out_valid);
        end
        send_row(16'h0000, 16'h0002, 8);
        total++;
        if (out_valid !== 1'b1 || out_data !== 16'h0010) begin
            bad++;
            $display("FAIL clear_row: got valid=%b data=%h want valid=1 data=0010", out_valid, out_data);
        end
        // Clear must also discard a pending result.
        out_ready = 1'b0;
        clear     = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL clear_pending: got valid=%b rdy=%b want valid=0 rdy=1", out_valid, in_ready);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_async_reset();
        send_row(16'h0000, 16'h0100, 4);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_data !== 16'h0000 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL async_rst: got vld=%b rdy=%b busy=%b data=%h ovf=%b want 0/1/0/0000/0",
                     out_valid, in_ready, busy, out_data, ovf);
        end
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        send_row(16'h0004, 16'h0001, 8);
        total++;
        if (out_valid !== 1'b1 || out_data !== 16'h000C) begin
            bad++;
            $display("FAIL async_rst_row: got valid=%b data=%h want valid=1 data=000c", out_valid, out_data);
        end
        drain();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic_row();
        test_pos_overflow();
        test_neg_overflow();
        test_backpressure();
        test_clear();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
